qed_dup_sequencer: RTL and testbench
====================================

# qed_dup_sequencer

Mode sequencer and final instruction mux for the QED front end. It sits directly downstream of the QED instruction queue. It generates `exec_dup`, which tells the queue whether to insert or replay. It selects the instruction driven into decode: the original fetched instruction, the replayed duplicate, or an `l.nop` bubble. It also pulses a consistency-check strobe once every original in a batch has had its duplicate issued.

## Interface
Parameters:
- `DUP_THRESHOLD`, default 64: number of recorded originals that forces the switch to duplicate mode. Legal range is 1..126, which keeps the 7-bit queue from ever filling.
- `IDLE_TIMEOUT`, default 32: idle-cycle limit. Used only with `QED_IDLE_FLUSH_EN`.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset. One clock; reset is synchronous and active-high.
- `qed_ena`, in, 1: QED checking enabled.
- `qed_force_dup`, in, 1: request an early switch to duplicate mode.
- `IF_stall`, in, 1: fetch stage stalled.
- `ifu_qimux_instruction`, in, 32: original fetched instruction.
- `qic_qimux_instruction`, in, 32: instruction from the queue.
- `qic_vld_out`, in, 1: queue inserted or deleted an entry this cycle.
- `exec_dup`, out, 1: registered mode bit sent to the queue.
- `qimux_instruction`, out, 32: instruction driven to decode.
- `qed_check`, out, 1: one-cycle registered strobe meaning "batch complete, compare state now".
- `qed_pending`, out, 7: originals recorded and not yet replayed.

## Operation
- The state is 2 bits: IDLE, ORIG, DUP, CHECK.
- `exec_dup` is 1 only in DUP. `qed_check` is 1 only in CHECK.
- The NOP word is 0x15000000.
- `qimux_instruction` is combinational, selected by state:
  - IDLE and ORIG: `ifu_qimux_instruction`.
  - DUP: `qic_qimux_instruction` if `qic_vld_out`, otherwise NOP.
  - CHECK: NOP.
- The counter `cnt` is 7 bits and drives `qed_pending`.
  - In ORIG it increments on `qic_vld_out`.
  - In DUP it decrements on `qic_vld_out`.
  - It holds in IDLE and CHECK.
  - It never wraps, because the threshold guarantees `cnt` ≤ 126.
- Transitions, evaluated at the clock edge, first matching rule wins:
  - IDLE → ORIG when `qed_ena`.
  - ORIG, where next_cnt is the post-increment value:
    - next_cnt == `DUP_THRESHOLD` → DUP.
    - `qed_force_dup` or `~qed_ena`, with next_cnt > 0 → DUP.
    - `~qed_ena` with next_cnt == 0 → IDLE.
    - `qed_force_dup` with next_cnt == 0 is ignored.
  - DUP → CHECK when next_cnt == 0.
  - CHECK → ORIG if `qed_ena`, otherwise IDLE.
- `qed_force_dup` and `qed_ena` are ignored in DUP; the batch always drains.
- In ORIG, originals that are stalled, NOPs, or not inserted do not change `cnt`. The queue's `vld_out` already excludes them.

## Timing
- Reset values: state IDLE, `cnt` 0, `exec_dup` 0, `qed_check` 0, `qed_pending` 0. `qimux_instruction` equals `ifu_qimux_instruction` after reset.
- Reset mid-batch discards `cnt` immediately, in the same edge as the queue's own reset.
- Zero-cycle latency from inputs to `qimux_instruction`.
- `exec_dup`, `qed_check` and `qed_pending` are flop outputs, valid the cycle after the triggering edge.
- The first DUP cycle follows the edge on which the threshold-reaching insert occurred. No extra insert is possible in between.
- During a DUP cycle with `IF_stall` high, the queue does not delete, so the output is NOP and `cnt` holds.
- CHECK lasts exactly one cycle. Decode sees a NOP during it.

## Configuration
- Macro `QED_IDLE_FLUSH_EN`.
- Defined:
  - An 8-bit idle counter is added. It clears on any ORIG-state `qic_vld_out`, or on leaving ORIG, and increments in ORIG otherwise.
  - ORIG → DUP when the idle counter reaches `IDLE_TIMEOUT` and `cnt` > 0. This rule has priority just below the threshold rule.
  - The purpose is to flush small batches when the program loops on NOPs or stalls.
- Undefined: no idle counter. Batches end only by threshold, force, or disable.

## Test plan
- Reset with `qed_ena`=1, then 64 consecutive `qic_vld_out` pulses → `exec_dup` rises on the cycle after the 64th pulse and `qed_pending`=64.
- DUP with `qic_vld_out` on alternate cycles and `qic_qimux_instruction`=0xE0221000 → the output alternates 0xE0221000 / 0x15000000. After 64 deletes, `qed_check` is high for exactly 1 cycle, then the state returns to ORIG with `qed_pending`=0.
- 3 inserts, then `qed_force_dup`=1 → DUP, 3 replays, CHECK. Force with `cnt`=0 → the state stays ORIG.
- `qed_ena` dropped with `cnt`=5 → 5 replays complete, CHECK, then IDLE with `exec_dup`=0.
- `rst` asserted in DUP with `cnt`=10 → the next cycle shows IDLE, `exec_dup`=0, `qed_pending`=0.
- `QED_IDLE_FLUSH_EN` defined with `IDLE_TIMEOUT`=32: 2 inserts, then 32 cycles without `qic_vld_out` → `exec_dup`=1. Undefined → the state stays ORIG.

Source files
------------

// File: rtl/qed_dup_sequencer.sv
// qed_dup_sequencer
//   Mode sequencer and final instruction mux for the QED front end. Sits
//   directly downstream of the QED instruction queue: tells the queue whether
//   to insert originals or replay duplicates (exec_dup), picks the word sent
//   to decode (original, duplicate, or l.nop bubble) and strobes qed_check
//   once every original of a batch has had its duplicate issued.
//
// Ports
//   clk                    clock
//   rst                    synchronous active-high reset
//   qed_ena                QED checking enabled
//   qed_force_dup          request an early switch to duplicate mode
//   IF_stall               fetch stage stalled
//   ifu_qimux_instruction  original fetched instruction
//   qic_qimux_instruction  instruction coming out of the queue
//   qic_vld_out            queue inserted/deleted an entry this cycle
//   exec_dup               registered mode bit to the queue (1 = replay)
//   qimux_instruction      instruction to decode (combinational)
//   qed_check              one-cycle registered "batch complete" strobe
//   qed_pending            originals recorded and not yet replayed
//
// Parameters
//   DUP_THRESHOLD  originals that force duplicate mode (1..126)
//   IDLE_TIMEOUT   idle cycles before a small batch is flushed (1..255)
//
// Build option
//   QED_IDLE_FLUSH_EN  adds an idle counter that flushes a non-empty batch
//                      after IDLE_TIMEOUT cycles in ORIG without an insert.
//
// State table
//   state    | meaning
//   ST_IDLE  | QED disabled, originals pass straight through
//   ST_ORIG  | recording originals into the queue
//   ST_DUP   | replaying duplicates from the queue until the batch drains
//   ST_CHECK | single bubble cycle, consistency check strobe
module qed_dup_sequencer #(
  parameter int unsigned DUP_THRESHOLD = 64,
  parameter int unsigned IDLE_TIMEOUT  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        qed_ena,
  input  logic        qed_force_dup,
  input  logic        IF_stall,
  input  logic [31:0] ifu_qimux_instruction,
  input  logic [31:0] qic_qimux_instruction,
  input  logic        qic_vld_out,
  output logic        exec_dup,
  output logic [31:0] qimux_instruction,
  output logic        qed_check,
  output logic [6:0]  qed_pending
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ORIG  = 2'd1,
    ST_DUP   = 2'd2,
    ST_CHECK = 2'd3
  } state_e;

  localparam logic [31:0] NOP_WORD = 32'h1500_0000;
  localparam logic [6:0]  THRESH   = 7'(DUP_THRESHOLD);

  if (DUP_THRESHOLD < 1 || DUP_THRESHOLD > 126) begin : g_bad_thresh
    $error("DUP_THRESHOLD out of range 1..126");
  end
  if (IDLE_TIMEOUT < 1 || IDLE_TIMEOUT > 255) begin : g_bad_timeout
    $error("IDLE_TIMEOUT out of range 1..255");
  end

  state_e     state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic       exec_dup_q, qed_check_q;
  logic       dup_del;
  logic       flush_hit;

  // A stalled fetch never sees a delete; gating here keeps the bubble and
  // the held count even if the queue strobe were to leak through.
  assign dup_del = qic_vld_out & ~IF_stall;

`ifdef QED_IDLE_FLUSH_EN
  localparam logic [7:0] IDLE_LIM = 8'(IDLE_TIMEOUT);
  logic [7:0] idle_q, idle_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    flush_hit = 1'b0;
`ifdef QED_IDLE_FLUSH_EN
    idle_d    = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (qed_ena) state_d = ST_ORIG;
      end
      ST_ORIG: begin
        cnt_d = cnt_q + {6'd0, qic_vld_out};
`ifdef QED_IDLE_FLUSH_EN
        // Saturating so a long idle stretch with an empty batch cannot wrap.
        if (!qic_vld_out) idle_d = (idle_q == 8'hFF) ? idle_q : idle_q + 8'd1;
        flush_hit = (idle_d >= IDLE_LIM);
`endif
        if (cnt_d == THRESH)                                   state_d = ST_DUP;
        else if (flush_hit && cnt_d != '0)                     state_d = ST_DUP;
        else if ((qed_force_dup || !qed_ena) && cnt_d != '0)   state_d = ST_DUP;
        else if (!qed_ena)                                     state_d = ST_IDLE;
`ifdef QED_IDLE_FLUSH_EN
        if (state_d != ST_ORIG) idle_d = '0;
`endif
      end
      ST_DUP: begin
        // Entered only with a non-empty batch, so this cannot underflow.
        cnt_d = cnt_q - {6'd0, dup_del};
        if (cnt_d == '0) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        state_d = qed_ena ? ST_ORIG : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      exec_dup_q  <= 1'b0;
      qed_check_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      exec_dup_q  <= (state_d == ST_DUP);
      qed_check_q <= (state_d == ST_CHECK);
    end
  end

`ifdef QED_IDLE_FLUSH_EN
  always_ff @(posedge clk) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end
`endif

  always_comb begin
    qimux_instruction = ifu_qimux_instruction;
    case (state_q)
      ST_DUP:   qimux_instruction = dup_del ? qic_qimux_instruction : NOP_WORD;
      ST_CHECK: qimux_instruction = NOP_WORD;
      default:  qimux_instruction = ifu_qimux_instruction;
    endcase
  end

  assign exec_dup    = exec_dup_q;
  assign qed_check   = qed_check_q;
  assign qed_pending = cnt_q;

endmodule

// File: tb/tb_qed_dup_sequencer.sv
module tb_qed_dup_sequencer;

  localparam int THR = 64;
  localparam int TO  = 32;
  localparam logic [31:0] NOP = 32'h1500_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        qed_ena = 1'b0;
  logic        qed_force_dup = 1'b0;
  logic        IF_stall = 1'b0;
  logic [31:0] ifu_qimux_instruction = 32'h0;
  logic [31:0] qic_qimux_instruction = 32'h0;
  logic        qic_vld_out = 1'b0;
  logic        exec_dup;
  logic [31:0] qimux_instruction;
  logic        qed_check;
  logic [6:0]  qed_pending;

  int total = 0;
  int bad   = 0;

  // reference model
  int m_st   = 0;  // 0 IDLE, 1 ORIG, 2 DUP, 3 CHECK
  int m_cnt  = 0;
  int m_idle = 0;

  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  qed_dup_sequencer #(.DUP_THRESHOLD(THR), .IDLE_TIMEOUT(TO)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .qed_ena               (qed_ena),
    .qed_force_dup         (qed_force_dup),
    .IF_stall              (IF_stall),
    .ifu_qimux_instruction (ifu_qimux_instruction),
    .qic_qimux_instruction (qic_qimux_instruction),
    .qic_vld_out           (qic_vld_out),
    .exec_dup              (exec_dup),
    .qimux_instruction     (qimux_instruction),
    .qed_check             (qed_check),
    .qed_pending           (qed_pending)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic sb_check(input string tag, input logic [31:0] got);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty, got=%h", tag, got);
    end else begin
      e = exp_q.pop_front();
      chk(tag, got, e);
    end
  endtask

  function automatic logic [31:0] model_mux(input logic stall, input logic vld,
                                            input logic [31:0] ifu, input logic [31:0] qic);
    if (m_st == 2) return (vld && !stall) ? qic : NOP;
    if (m_st == 3) return NOP;
    return ifu;
  endfunction

  function automatic void model_step(input logic ena, input logic frc,
                                     input logic stall, input logic vld);
    int ns, nc, ni;
    ns = m_st;
    nc = m_cnt;
    ni = 0;
    case (m_st)
      0: if (ena) ns = 1;
      1: begin
        nc = m_cnt + (vld ? 1 : 0);
        ni = vld ? 0 : ((m_idle < 255) ? m_idle + 1 : 255);
        if (nc == THR) ns = 2;
`ifdef QED_IDLE_FLUSH_EN
        else if (ni >= TO && nc > 0) ns = 2;
`endif
        else if ((frc || !ena) && nc > 0) ns = 2;
        else if (!ena) ns = 0;
        if (ns != 1) ni = 0;
      end
      2: begin
        if (vld && !stall) nc = m_cnt - 1;
        if (nc == 0) ns = 3;
      end
      default: ns = ena ? 1 : 0;
    endcase
    m_st   = ns;
    m_cnt  = nc;
    m_idle = ni;
  endfunction

  task automatic push_regs();
    exp_q.push_back({31'd0, m_st == 2});
    exp_q.push_back({31'd0, m_st == 3});
    exp_q.push_back(32'(m_cnt));
  endtask

  task automatic pop_regs();
    sb_check("exec_dup", {31'd0, exec_dup});
    sb_check("qed_check", {31'd0, qed_check});
    sb_check("qed_pending", {25'd0, qed_pending});
  endtask

  task automatic cyc(input logic ena, input logic frc, input logic stall, input logic vld,
                     input logic [31:0] ifu, input logic [31:0] qic);
    @(negedge clk);
    rst = 1'b0;
    qed_ena = ena;
    qed_force_dup = frc;
    IF_stall = stall;
    qic_vld_out = vld;
    ifu_qimux_instruction = ifu;
    qic_qimux_instruction = qic;
    #1;
    exp_q.push_back(model_mux(stall, vld, ifu, qic));
    sb_check("qimux", qimux_instruction);
    @(posedge clk);
    model_step(ena, frc, stall, vld);
    push_regs();
    #1;
    pop_regs();
  endtask

  task automatic do_reset(input logic ena);
    @(negedge clk);
    rst = 1'b1;
    qed_ena = ena;
    qed_force_dup = 1'b0;
    IF_stall = 1'b0;
    qic_vld_out = 1'b0;
    ifu_qimux_instruction = 32'hA5A5_0001;
    @(posedge clk);
    m_st = 0;
    m_cnt = 0;
    m_idle = 0;
    #1;
    chk("rst_exec_dup", {31'd0, exec_dup}, 32'd0);
    chk("rst_qed_check", {31'd0, qed_check}, 32'd0);
    chk("rst_pending", {25'd0, qed_pending}, 32'd0);
    chk("rst_qimux", qimux_instruction, 32'hA5A5_0001);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with checking enabled, then a full threshold batch
    do_reset(1'b1);
    cyc(1, 0, 0, 0, 32'h1111_0000, 32'h0);
    for (int i = 0; i < THR; i++) begin
      cyc(1, 0, 0, 1, 32'h2000_0000 + 32'(i), $urandom);
      if (i == THR - 2) chk("pre_thr_exec_dup", {31'd0, exec_dup}, 32'd0);
    end
    chk("thr_exec_dup", {31'd0, exec_dup}, 32'd1);
    chk("thr_pending", {25'd0, qed_pending}, 32'd64);

    // drain with deletes on alternate cycles, stalls sprinkled in the gaps
    for (int i = 0; i < 2 * THR - 1; i++) begin
      cyc(1, (i % 7) == 3, (i % 4) == 1, (i % 2) == 0, $urandom, 32'hE022_1000);
      if (i == 1) chk("dup_gap_nop", qimux_instruction, NOP);
    end
    chk("drain_check_hi", {31'd0, qed_check}, 32'd1);
    cyc(1, 0, 0, 0, 32'h3333_0000, 32'h0);
    chk("drain_check_lo", {31'd0, qed_check}, 32'd0);
    chk("drain_exec_lo", {31'd0, exec_dup}, 32'd0);
    chk("drain_pending0", {25'd0, qed_pending}, 32'd0);

    // early force after 3 inserts
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, $urandom, $urandom);
    cyc(1, 1, 0, 0, $urandom, $urandom);
    chk("force_exec_dup", {31'd0, exec_dup}, 32'd1);
    chk("force_pending", {25'd0, qed_pending}, 32'd3);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, $urandom, 32'hC0DE_0000 + 32'(i));
    chk("force_check", {31'd0, qed_check}, 32'd1);
    cyc(1, 0, 0, 0, $urandom, $urandom);

    // force with an empty batch is ignored
    cyc(1, 1, 0, 0, $urandom, $urandom);
    chk("force_empty_exec", {31'd0, exec_dup}, 32'd0);
    cyc(1, 1, 1, 0, $urandom, $urandom);

    // disable with 5 pending drains then goes idle
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1, $urandom, $urandom);
    cyc(0, 0, 0, 0, $urandom, $urandom);
    chk("dis_exec_dup", {31'd0, exec_dup}, 32'd1);
    chk("dis_pending", {25'd0, qed_pending}, 32'd5);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, $urandom, $urandom);
    chk("dis_check", {31'd0, qed_check}, 32'd1);
    cyc(0, 0, 0, 0, $urandom, $urandom);
    chk("dis_idle_exec", {31'd0, exec_dup}, 32'd0);
    cyc(0, 0, 0, 1, 32'h4444_4444, 32'h5555_5555);

    // reset while replaying a 10-entry batch
    cyc(1, 0, 0, 0, $urandom, $urandom);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 1, $urandom, $urandom);
    cyc(1, 1, 0, 0, $urandom, $urandom);
    chk("mid_exec_dup", {31'd0, exec_dup}, 32'd1);
    chk("mid_pending", {25'd0, qed_pending}, 32'd10);
    do_reset(1'b1);

    // idle flush: 2 inserts then 32 idle cycles
    cyc(1, 0, 0, 0, $urandom, $urandom);
    for (int i = 0; i < 2; i++) cyc(1, 0, 0, 1, $urandom, $urandom);
    for (int i = 0; i < TO; i++) cyc(1, 0, i[0], 0, $urandom, $urandom);
`ifdef QED_IDLE_FLUSH_EN
    chk("idle_flush_exec", {31'd0, exec_dup}, 32'd1);
`else
    chk("idle_flush_exec", {31'd0, exec_dup}, 32'd0);
`endif
    chk("idle_flush_pend", {25'd0, qed_pending}, 32'd2);
    cyc(1, 1, 0, 0, $urandom, $urandom);
    for (int i = 0; i < 2; i++) cyc(1, 0, 0, 1, $urandom, $urandom);
    chk("idle_flush_check", {31'd0, qed_check}, 32'd1);
    cyc(1, 0, 0, 0, $urandom, $urandom);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 15) != 0), ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1, $urandom, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
